// File: rtl/lut_neuron_pipe_if.sv
// Handshake and configuration bundle for lut_neuron_pipe.
// master drives the table load stream and the input words and accepts results;
// slave is the neuron itself.
interface lut_neuron_pipe_if #(
    parameter int IN_BITS  = 8,
    parameter int OUT_BITS = 2
);
    logic                cfg_start;
    logic                cfg_valid;
    logic [OUT_BITS-1:0] cfg_data;
    logic                cfg_ready;
    logic                table_loaded;
    logic                in_valid;
    logic                in_ready;
    logic [IN_BITS-1:0]  in_data;
    logic                out_valid;
    logic                out_ready;
    logic [OUT_BITS-1:0] out_data;

    modport master (
        output cfg_start, cfg_valid, cfg_data, in_valid, in_data, out_ready,
        input  cfg_ready, table_loaded, in_ready, out_valid, out_data
    );

    modport slave (
        input  cfg_start, cfg_valid, cfg_data, in_valid, in_data, out_ready,
        output cfg_ready, table_loaded, in_ready, out_valid, out_data
    );
endinterface

// File: rtl/lut_neuron_pipe.sv
// Table-lookup neuron: a 2^IN_BITS x OUT_BITS truth table is streamed in,
// then each input word addresses it through a two-stage pipeline.
// Reloading from RUN first drains the words already in flight.
module lut_neuron_pipe #(
    parameter int IN_BITS  = 8,
    parameter int OUT_BITS = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    lut_neuron_pipe_if.slave  bus
);
    localparam int DEPTH = 1 << IN_BITS;
    localparam logic [IN_BITS:0] LAST = (IN_BITS + 1)'(DEPTH - 1);

    typedef enum logic [1:0] {EMPTY, LOAD, DRAIN, RUN} state_t;

    state_t              state;
    logic [IN_BITS:0]    cnt;
    logic                cfg_ready_r;
    logic                table_loaded_r;
    logic                s1_valid;
    logic [IN_BITS-1:0]  s1_addr;
    logic                s2_valid;
    logic [OUT_BITS-1:0] out_data_r;
    logic [OUT_BITS-1:0] mem [DEPTH];

    logic                advance1;
    logic                in_ready_c;
    logic                accept_in;
    logic                accept_cfg;
    logic [IN_BITS-1:0]  wr_addr;

    // Handshake decode; cfg_start masks in_ready so a reload request wins over a same-cycle input
    always_comb begin
        advance1   = !s2_valid || bus.out_ready;
        in_ready_c = (state == RUN) && !bus.cfg_start && (!s1_valid || advance1);
        accept_in  = bus.in_valid && in_ready_c;
        accept_cfg = bus.cfg_valid && cfg_ready_r;
        wr_addr    = bus.cfg_start ? '0 : cnt[IN_BITS-1:0];
    end

    // Control FSM: load sequencing, drain before reload, registered status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= EMPTY;
            cnt            <= '0;
            cfg_ready_r    <= 1'b0;
            table_loaded_r <= 1'b0;
        end else begin
            case (state)
                EMPTY: begin
                    if (bus.cfg_start) begin
                        state          <= LOAD;
                        cnt            <= '0;
                        cfg_ready_r    <= 1'b1;
                        table_loaded_r <= 1'b0;
                    end
                end
                LOAD: begin
                    if (bus.cfg_start) begin
                        cnt <= '0;
                    end else if (accept_cfg) begin
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST) begin
                            state          <= RUN;
                            cfg_ready_r    <= 1'b0;
                            table_loaded_r <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (!s1_valid && !s2_valid) begin
                        state          <= LOAD;
                        cnt            <= '0;
                        cfg_ready_r    <= 1'b1;
                        table_loaded_r <= 1'b0;
                    end
                end
                RUN: begin
                    if (bus.cfg_start) begin
                        state <= DRAIN;
                    end
                end
                default: begin
                    state <= EMPTY;
                end
            endcase
        end
    end

    // Truth table storage; contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (accept_cfg) begin
            mem[wr_addr] <= bus.cfg_data;
        end
    end

    // Two-stage lookup pipeline with backpressure from out_ready
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid   <= 1'b0;
            s1_addr    <= '0;
            s2_valid   <= 1'b0;
            out_data_r <= '0;
        end else begin
            if (accept_in) begin
                s1_valid <= 1'b1;
                s1_addr  <= bus.in_data;
            end else if (advance1) begin
                s1_valid <= 1'b0;
            end
            if (advance1) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    out_data_r <= mem[s1_addr];
                end
            end
        end
    end

    assign bus.cfg_ready    = cfg_ready_r;
    assign bus.table_loaded = table_loaded_r;
    assign bus.in_ready     = in_ready_c;
    assign bus.out_valid    = s2_valid;
    assign bus.out_data     = out_data_r;
endmodule
